// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO arbiter.
package pio_pkg;

  localparam logic PIO_READ  = 1'b0;
  localparam logic PIO_WRITE = 1'b1;

  typedef enum logic {IDLE, RD_WAIT} pio_arb_state_e;

endpackage

// File: rtl/pio_rr_arb.sv
// Combinational round-robin pick: the first requester at or after rr_ptr, with wrap-around.
module pio_rr_arb #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/pio_arb.sv
// N-master round-robin arbiter in front of a single legacy PIO slave, with one
// outstanding read at a time and a timeout that returns an error response.
module pio_arb
  import pio_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_MASTERS-1:0]        m_cmd_vld,
  output logic [N_MASTERS-1:0]        m_cmd_rdy,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_data_w,
  input  logic [N_MASTERS-1:0]        m_rw,
  output logic [DATA_W-1:0]           m_data_r,
  output logic [N_MASTERS-1:0]        m_rd_vld,
  output logic                        m_rd_err,
  output logic                        s_cmd_vld,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_data_w,
  output logic                        s_rw,
  input  logic [DATA_W-1:0]           s_data_r,
  input  logic                        s_rd_vld,
  output logic                        late_rsp
);

  localparam int PW = $clog2(N_MASTERS);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [PW-1:0]        LAST_M   = PW'(N_MASTERS - 1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ONE_HOT0 = N_MASTERS'(1);

  pio_arb_state_e    state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [CW-1:0]     cnt;
  logic [N_MASTERS-1:0] grant;
  logic [PW-1:0]     grant_idx;
  logic              any_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_rw;

  pio_rr_arb #(.N(N_MASTERS), .PW(PW)) u_rr (
    .req       (m_cmd_vld),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign sel_addr = m_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data = m_data_w[grant_idx*DATA_W +: DATA_W];
  assign sel_rw   = m_rw[grant_idx];

  // Ready is combinational so a granted master sees its accept in the same cycle.
  assign m_cmd_rdy = (state == IDLE && !reset) ? grant : '0;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cnt       <= '0;
      s_cmd_vld <= 1'b0;
      s_addr    <= '0;
      s_data_w  <= '0;
      s_rw      <= 1'b0;
      m_data_r  <= '0;
      m_rd_vld  <= '0;
      m_rd_err  <= 1'b0;
      late_rsp  <= 1'b0;
    end else begin
      s_cmd_vld <= 1'b0;
      m_rd_vld  <= '0;
      m_rd_err  <= 1'b0;
      if (state == IDLE) begin
        // A slave answer with nothing pending is dropped but remembered.
        if (s_rd_vld) late_rsp <= 1'b1;
        if (any_grant) begin
          s_cmd_vld <= 1'b1;
          s_addr    <= sel_addr;
          s_data_w  <= sel_data;
          s_rw      <= sel_rw;
          rr_ptr    <= (grant_idx == LAST_M) ? '0 : grant_idx + 1'b1;
          if (sel_rw == PIO_READ) begin
            owner <= grant_idx;
            cnt   <= '0;
            state <= RD_WAIT;
          end
        end
      end else begin
        if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        // A real answer on the expiry cycle takes priority over the error.
        if (s_rd_vld) begin
          m_data_r <= s_data_r;
          m_rd_vld <= ONE_HOT0 << owner;
          state    <= IDLE;
        end else if (cnt == CNT_LAST) begin
          m_data_r <= '0;
          m_rd_vld <= ONE_HOT0 << owner;
          m_rd_err <= 1'b1;
          state    <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pio_arb.sv
// Directed and randomized checks of pio_arb against a cycle-level transaction model.
module tb_pio_arb;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    m_cmd_vld;
  logic [N-1:0]    m_cmd_rdy;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_data_w;
  logic [N-1:0]    m_rw;
  logic [DW-1:0]   m_data_r;
  logic [N-1:0]    m_rd_vld;
  logic            m_rd_err;
  logic            s_cmd_vld;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_data_w;
  logic            s_rw;
  logic [DW-1:0]   s_data_r;
  logic            s_rd_vld;
  logic            late_rsp;

  always #5 clk = ~clk;

  pio_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_cmd_vld (m_cmd_vld),
    .m_cmd_rdy (m_cmd_rdy),
    .m_addr    (m_addr),
    .m_data_w  (m_data_w),
    .m_rw      (m_rw),
    .m_data_r  (m_data_r),
    .m_rd_vld  (m_rd_vld),
    .m_rd_err  (m_rd_err),
    .s_cmd_vld (s_cmd_vld),
    .s_addr    (s_addr),
    .s_data_w  (s_data_w),
    .s_rw      (s_rw),
    .s_data_r  (s_data_r),
    .s_rd_vld  (s_rd_vld),
    .late_rsp  (late_rsp)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: pending owner (-1 = none), RD_WAIT cycles elapsed, next-grant pointer.
  bit            mv = 1'b0;
  int            m_ptr = 0;
  int            m_pend = -1;
  int            m_waited = 0;
  logic [N-1:0]  e_rdy = '0;
  logic          e_s_vld, e_s_rw, e_err, e_late;
  logic [AW-1:0] e_s_addr;
  logic [DW-1:0] e_s_data, e_data_r;
  logic [N-1:0]  e_rd_vld;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    int g;
    g = -1;
    @(negedge clk);
    if (mv) begin
      check("s_cmd_vld", 64'(s_cmd_vld), 64'(e_s_vld));
      check("s_addr",    64'(s_addr),    64'(e_s_addr));
      check("s_data_w",  64'(s_data_w),  64'(e_s_data));
      check("s_rw",      64'(s_rw),      64'(e_s_rw));
      check("m_rd_vld",  64'(m_rd_vld),  64'(e_rd_vld));
      check("m_rd_err",  64'(m_rd_err),  64'(e_err));
      check("m_data_r",  64'(m_data_r),  64'(e_data_r));
      check("late_rsp",  64'(late_rsp),  64'(e_late));
    end
    e_rdy = '0;
    if (!reset && mv && m_pend < 0) begin
      g = pick(m_cmd_vld, m_ptr);
      if (g >= 0) e_rdy[g] = 1'b1;
    end
    if (reset || mv) check("m_cmd_rdy", 64'(m_cmd_rdy), 64'(e_rdy));

    e_s_vld  = 1'b0;
    e_rd_vld = '0;
    e_err    = 1'b0;
    if (reset) begin
      mv = 1'b1; m_ptr = 0; m_pend = -1; m_waited = 0;
      e_s_addr = '0; e_s_data = '0; e_s_rw = 1'b0; e_data_r = '0; e_late = 1'b0;
    end else if (m_pend < 0) begin
      if (s_rd_vld) e_late = 1'b1;
      if (g >= 0) begin
        e_s_vld  = 1'b1;
        e_s_addr = m_addr[g*AW +: AW];
        e_s_data = m_data_w[g*DW +: DW];
        e_s_rw   = m_rw[g];
        m_ptr    = (g + 1) % N;
        if (m_rw[g] == 1'b0) begin
          m_pend   = g;
          m_waited = 0;
        end
      end
    end else begin
      m_waited++;
      if (s_rd_vld) begin
        e_rd_vld[m_pend] = 1'b1;
        e_data_r = s_data_r;
        m_pend = -1;
      end else if (m_waited == TO) begin
        e_rd_vld[m_pend] = 1'b1;
        e_err = 1'b1;
        e_data_r = '0;
        m_pend = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_rw[i] = rw;
    m_addr[i*AW +: AW] = a;
    m_data_w[i*DW +: DW] = d;
  endtask

  initial begin
    reset = 1'b1; m_cmd_vld = '0; m_addr = '0; m_data_w = '0; m_rw = '0;
    s_data_r = '0; s_rd_vld = 1'b0;

    // Reset: ready stays low even with every master requesting.
    m_cmd_vld = 4'hF;
    tick(); tick();
    check("rst_rdy", 64'(m_cmd_rdy), 64'h0);
    check("rst_s_vld", 64'(s_cmd_vld), 64'h0);
    check("rst_late", 64'(late_rsp), 64'h0);

    // Continuous writes from all masters: grants rotate 0,1,2,3,0 at one per cycle.
    for (int i = 0; i < N; i++) set_cmd(i, 1'b1, AW'(16'h1000 + i), DW'(32'hD000_0000 + i));
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("wr_rr_vld", 64'(s_cmd_vld), 64'h1);
      check("wr_rr_addr", 64'(s_addr), 64'(16'h1000 + (k % N)));
    end

    // Master 2 reads 0x0010, slave answers three cycles after the command.
    m_cmd_vld = 4'b0100;
    set_cmd(2, 1'b0, 16'h0010, 32'h0);
    tick();
    m_cmd_vld = 4'b0001;
    check("rd2_issue_rw", 64'(s_rw), 64'h0);
    check("rd2_issue_addr", 64'(s_addr), 64'h0010);
    for (int k = 0; k < 3; k++) begin
      check("rd2_no_grant", 64'(m_cmd_rdy), 64'h0);
      tick();
    end
    s_rd_vld = 1'b1; s_data_r = 32'hCAFE_0002;
    tick();
    s_rd_vld = 1'b0;
    check("rd2_vld", 64'(m_rd_vld), 64'b0100);
    check("rd2_data", 64'(m_data_r), 64'hCAFE_0002);
    check("rd2_err", 64'(m_rd_err), 64'h0);
    tick();
    m_cmd_vld = '0;
    check("rd2_pulse", 64'(m_rd_vld), 64'h0);
    check("rd2_next_grant", 64'(s_addr), 64'h1000);

    // Master 1 reads, slave silent: error pulse exactly TO cycles after the command.
    m_cmd_vld = 4'b0010;
    set_cmd(1, 1'b0, 16'h0020, 32'h0);
    tick();
    m_cmd_vld = '0;
    for (int k = 0; k < TO - 1; k++) tick();
    check("to_early", 64'(m_rd_vld), 64'h0);
    tick();
    check("to_vld", 64'(m_rd_vld), 64'b0010);
    check("to_err", 64'(m_rd_err), 64'h1);
    check("to_data", 64'(m_data_r), 64'h0);
    s_rd_vld = 1'b1; s_data_r = 32'h0000_0BAD;
    tick();
    s_rd_vld = 1'b0;
    check("to_late", 64'(late_rsp), 64'h1);
    check("to_late_no_vld", 64'(m_rd_vld), 64'h0);

    // Answer lands on the expiry cycle: real data wins, no late flag.
    reset = 1'b1; tick(); reset = 1'b0;
    check("late_cleared", 64'(late_rsp), 64'h0);
    m_cmd_vld = 4'b0010;
    tick();
    m_cmd_vld = '0;
    for (int k = 0; k < TO - 1; k++) tick();
    check("tie_early", 64'(m_rd_vld), 64'h0);
    s_rd_vld = 1'b1; s_data_r = 32'h1234_5678;
    tick();
    s_rd_vld = 1'b0;
    check("tie_vld", 64'(m_rd_vld), 64'b0010);
    check("tie_err", 64'(m_rd_err), 64'h0);
    check("tie_data", 64'(m_data_r), 64'h1234_5678);
    tick();
    check("tie_no_late", 64'(late_rsp), 64'h0);

    // Reset while master 3's read is pending abandons it.
    m_cmd_vld = 4'b1000;
    set_cmd(3, 1'b0, 16'h0030, 32'h0);
    tick();
    m_cmd_vld = '0;
    tick();
    reset = 1'b1; s_rd_vld = 1'b1; s_data_r = 32'h55;
    tick();
    check("rstwait_vld", 64'(m_rd_vld), 64'h0);
    check("rstwait_late", 64'(late_rsp), 64'h0);
    reset = 1'b0;
    tick();
    s_rd_vld = 1'b0;
    check("rstwait_late_after", 64'(late_rsp), 64'h1);
    check("rstwait_no_vld", 64'(m_rd_vld), 64'h0);
    for (int i = 0; i < N; i++) set_cmd(i, 1'b1, AW'(16'h2000 + i), DW'(i));
    m_cmd_vld = 4'hF;
    tick();
    m_cmd_vld = '0;
    check("rstwait_ptr0", 64'(s_addr), 64'h2000);

    // Master 3 holds a request with a changing payload while master 0's read is pending.
    reset = 1'b1; tick(); reset = 1'b0;
    set_cmd(0, 1'b0, 16'h0040, 32'h0);
    set_cmd(3, 1'b1, 16'hDEAD, 32'h1);
    m_cmd_vld = 4'b1001;
    tick();
    m_cmd_vld = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      set_cmd(3, 1'b1, AW'($urandom), $urandom);
      check("hold_rdy3", 64'(m_cmd_rdy[3]), 64'h0);
      tick();
    end
    s_rd_vld = 1'b1; s_data_r = 32'hA5A5_0000;
    tick();
    s_rd_vld = 1'b0;
    set_cmd(3, 1'b1, 16'h0BEE, 32'h3333_3333);
    tick();
    m_cmd_vld = '0;
    check("hold_addr", 64'(s_addr), 64'h0BEE);
    check("hold_data", 64'(s_data_w), 64'h3333_3333);

    // Randomized traffic: masters keep requests until accepted; slave answers at random.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++) begin
        if (!m_cmd_vld[i] || e_rdy[i]) begin
          m_cmd_vld[i] = ($urandom_range(0, 2) != 0);
          set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        end
      end
      s_rd_vld = ($urandom_range(0, 5) == 0);
      s_data_r = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
